// File: rtl/fifo_flex_if.sv
// Producer/consumer bundle for fifo_flex: write port, pop port, status flags and error controls.
interface fifo_flex_if #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                  wr_en;
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic                  clr_err;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, data_in, rd_en, clr_err,
    input  data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, clr_err,
    output data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_flex.sv
// Single-clock FIFO with arbitrary depth, standard or FWFT read, programmable
// almost flags, occupancy count and sticky overflow/underflow.
module fifo_flex #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input logic       clk,
  input logic       rstN,
  fifo_flex_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  ovf, udf;
  logic                  is_empty, is_full, rd_ok, wr_ok;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == CW'(FIFO_DEPTH));
  assign rd_ok    = bus.rd_en & ~is_empty;
  // A full FIFO can still take a word when the same edge pops one.
  assign wr_ok    = bus.wr_en & (~is_full | rd_ok);

  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= bus.data_in;

  // Explicit wrap so depths that are not powers of two work.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) cnt <= '0;
    else begin
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky errors: a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= (bus.wr_en & ~wr_ok)    | (ovf & ~bus.clr_err);
      udf <= (bus.rd_en & is_empty)  | (udf & ~bus.clr_err);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.data_out = is_empty ? '0 : mem[rd_ptr];
    end else begin : g_std
      logic [FIFO_WIDTH-1:0] dout;
      always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)      dout <= '0;
        else if (rd_ok) dout <= mem[rd_ptr];
      end
      assign bus.data_out = dout;
    end
  endgenerate

  assign bus.count        = cnt;
  assign bus.empty        = is_empty;
  assign bus.full         = is_full;
  assign bus.almost_empty = (cnt <= CW'(AE_LEVEL));
  assign bus.almost_full  = (cnt >= CW'(AF_LEVEL));
  assign bus.overflow     = ovf;
  assign bus.underflow    = udf;
endmodule

// File: tb/tb_fifo_flex.sv
// Scoreboard bench for fifo_flex: depth-6 standard-mode and FWFT instances.
module tb_fifo_flex;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  fifo_flex_if #(.FIFO_WIDTH(8), .FIFO_DEPTH(6)) b0 ();
  fifo_flex_if #(.FIFO_WIDTH(8), .FIFO_DEPTH(6)) b1 ();

  fifo_flex #(.FIFO_WIDTH(8), .FIFO_DEPTH(6), .FWFT(0), .AF_LEVEL(4), .AE_LEVEL(1))
    dut0 (.clk(clk), .rstN(rstN), .bus(b0.slave));
  fifo_flex #(.FIFO_WIDTH(8), .FIFO_DEPTH(6), .FWFT(1), .AF_LEVEL(4), .AE_LEVEL(1))
    dut1 (.clk(clk), .rstN(rstN), .bus(b1.slave));

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Standard-mode read data is due one cycle after an accepted pop.
  always begin : monitor
    logic pend;
    logic [7:0] e;
    @(posedge clk);
    pend = rstN && b0.rd_en && !b0.empty;
    @(negedge clk);
    if (pend) begin
      if (exp_q.size() == 0) check("unexpected_read", {24'd0, b0.data_out}, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        check("read_data", {24'd0, b0.data_out}, {24'd0, e});
      end
    end
  end

  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    b0.wr_en = w; b0.data_in = d; b0.rd_en = r; b0.clr_err = c;
    @(posedge clk); #1;
    b0.wr_en = 1'b0; b0.rd_en = 1'b0; b0.clr_err = 1'b0;
  endtask

  task automatic cyc1(input logic w, input logic [7:0] d, input logic r);
    b1.wr_en = w; b1.data_in = d; b1.rd_en = r;
    @(posedge clk); #1;
    b1.wr_en = 1'b0; b1.rd_en = 1'b0;
  endtask

  initial begin
    b0.wr_en = 0; b0.data_in = 0; b0.rd_en = 0; b0.clr_err = 0;
    b1.wr_en = 0; b1.data_in = 0; b1.rd_en = 0; b1.clr_err = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(b0.count), 0);
    check("rst_empty", 32'(b0.empty), 1);
    check("rst_ae", 32'(b0.almost_empty), 1);
    check("rst_full", 32'(b0.full), 0);
    check("rst_af", 32'(b0.almost_full), 0);
    check("rst_ovf", 32'(b0.overflow), 0);
    check("rst_udf", 32'(b0.underflow), 0);
    check("rst_dout", 32'(b0.data_out), 0);
    @(negedge clk) rstN = 1'b1;
    @(posedge clk); #1;

    // Fill to full, then overflow
    for (int i = 0; i < 6; i++) begin
      cyc(1, 8'h11 + 8'(i), 0, 0);
      check("fill_count", 32'(b0.count), i + 1);
      check("fill_ae", 32'(b0.almost_empty), (i + 1 <= 1) ? 1 : 0);
      check("fill_af", 32'(b0.almost_full), (i + 1 >= 4) ? 1 : 0);
      check("fill_full", 32'(b0.full), (i == 5) ? 1 : 0);
    end
    cyc(1, 8'h77, 0, 0);
    check("ovf_set", 32'(b0.overflow), 1);
    check("ovf_count", 32'(b0.count), 6);

    // Simultaneous read/write while full
    exp_q.push_back(8'h11);
    cyc(1, 8'h88, 1, 0);
    check("rw_full_count", 32'(b0.count), 6);
    check("rw_full_full", 32'(b0.full), 1);
    check("rw_full_ovf", 32'(b0.overflow), 1);
    exp_q.push_back(8'h12); exp_q.push_back(8'h13); exp_q.push_back(8'h14);
    exp_q.push_back(8'h15); exp_q.push_back(8'h16); exp_q.push_back(8'h88);
    repeat (6) cyc(0, 8'h00, 1, 0);
    check("drain_count", 32'(b0.count), 0);
    check("drain_empty", 32'(b0.empty), 1);
    cyc(0, 8'h00, 0, 1);
    check("ovf_clr", 32'(b0.overflow), 0);

    // Interleaved write/read across pointer wrap
    for (int k = 0; k < 20; k++) begin
      cyc(1, 8'h20 + 8'(k), 0, 0);
      check("wrap_cnt_w", 32'(b0.count), 1);
      exp_q.push_back(8'h20 + 8'(k));
      cyc(0, 8'h00, 1, 0);
      check("wrap_cnt_r", 32'(b0.count), 0);
    end
    @(negedge clk);

    // Underflow with concurrent write into an empty FIFO
    cyc(1, 8'h5A, 1, 0);
    check("udf_set", 32'(b0.underflow), 1);
    check("udf_count", 32'(b0.count), 1);
    check("udf_dout_hold", 32'(b0.data_out), 32'h33);
    cyc(0, 8'h00, 0, 1);
    check("udf_clr", 32'(b0.underflow), 0);
    exp_q.push_back(8'h5A);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 1, 1);
    check("udf_set_wins", 32'(b0.underflow), 1);
    cyc(0, 8'h00, 0, 1);
    check("udf_clr2", 32'(b0.underflow), 0);

    // FWFT instance
    check("fwft_empty0", 32'(b1.empty), 1);
    cyc1(1, 8'hA5, 0);
    check("fwft_empty", 32'(b1.empty), 0);
    check("fwft_dout", 32'(b1.data_out), 32'hA5);
    check("fwft_count", 32'(b1.count), 1);
    cyc1(0, 8'h00, 1);
    check("fwft_pop_empty", 32'(b1.empty), 1);
    check("fwft_pop_count", 32'(b1.count), 0);
    cyc1(1, 8'hB1, 0);
    cyc1(1, 8'hB2, 0);
    check("fwft_head1", 32'(b1.data_out), 32'hB1);
    cyc1(0, 8'h00, 1);
    check("fwft_head2", 32'(b1.data_out), 32'hB2);
    cyc1(0, 8'h00, 1);

    // Mid-stream asynchronous reset
    cyc(0, 8'h00, 1, 0);
    check("pre_rst_udf", 32'(b0.underflow), 1);
    cyc(1, 8'h01, 0, 0);
    cyc(1, 8'h02, 0, 0);
    cyc(1, 8'h03, 0, 0);
    check("pre_rst_count", 32'(b0.count), 3);
    #2 rstN = 1'b0;
    #1;
    check("arst_count", 32'(b0.count), 0);
    check("arst_empty", 32'(b0.empty), 1);
    check("arst_ae", 32'(b0.almost_empty), 1);
    check("arst_udf", 32'(b0.underflow), 0);
    check("arst_dout", 32'(b0.data_out), 0);
    @(negedge clk) rstN = 1'b1;
    @(posedge clk); #1;
    cyc(1, 8'h3C, 0, 0);
    check("post_rst_count", 32'(b0.count), 1);
    exp_q.push_back(8'h3C);
    cyc(0, 8'h00, 1, 0);
    check("post_rst_empty", 32'(b0.empty), 1);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
- Parametrised synchronous FIFO. Next generation of the team's single-clock `fifo` block.
- Adds:
  - arbitrary (non-power-of-2) depth,
  - selectable standard or first-word-fall-through read mode,
  - programmable almost-full and almost-empty flags,
  - occupancy count output,
  - sticky overflow/underflow error flags.
- Drop-in replacement for `fifo` behind an extended `fifo_intf`. Sits between producer and consumer on one clock domain.

Parameters:
- FIFO_WIDTH, 8, data word width in bits (≥1)
- FIFO_DEPTH, 16, number of storage entries (≥2, any integer)
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
- AF_LEVEL, FIFO_DEPTH-2, almost_full asserted when count ≥ AF_LEVEL (1..FIFO_DEPTH)
- AE_LEVEL, 2, almost_empty asserted when count ≤ AE_LEVEL (0..FIFO_DEPTH-1)
- CW (localparam), $clog2(FIFO_DEPTH+1), count width

Ports:
- clk  in  1  clock, all state changes on rising edge
- rstN  in  1  asynchronous active-low reset
- wr_en  in  1  write request
- data_in  in  FIFO_WIDTH  write data
- rd_en  in  1  read request (pop)
- data_out  out  FIFO_WIDTH  read data
- empty  out  1  count == 0
- full  out  1  count == FIFO_DEPTH
- almost_empty  out  1  count ≤ AE_LEVEL
- almost_full  out  1  count ≥ AF_LEVEL
- count  out  CW  current occupancy, 0..FIFO_DEPTH
- overflow  out  1  sticky: write attempted while full and not accepted
- underflow  out  1  sticky: read attempted while empty
- clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (rstN low, async, any time):
  - pointers and count go to 0; data_out = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0 (almost_full = 1 only if AF_LEVEL = 0, which is illegal).
  - overflow = underflow = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored words. The first cycle after release behaves as an empty FIFO.
- Accept rules, evaluated on pre-edge state:
  - rd_ok = rd_en & !empty
  - wr_ok = wr_en & (!full | rd_ok). Write while full is accepted only with a concurrent accepted read.
  - Write while empty with concurrent rd_en: write accepted, read rejected, underflow sets.
- Pointers:
  - wr_ptr/rd_ptr advance by 1 on wr_ok/rd_ok.
  - Wrap from FIFO_DEPTH-1 to 0 (explicit compare, no modulo-2^n assumption).
- Count:
  - +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.
- Flags:
  - All flags are derived from the registered count.
  - All flags are valid in the cycle after the causing edge.
- Standard mode (FWFT=0):
  - On rd_ok, data_out registers mem[rd_ptr]; valid the cycle after the rd_en edge (latency 1).
  - data_out holds its last value otherwise, including on a rejected read.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] whenever !empty; rd_en acknowledges/pops the head.
  - A word written into an empty FIFO appears on data_out and empty deasserts one cycle after the write edge.
  - data_out is don't-care while empty.
- Errors:
  - overflow sets on wr_en & !wr_ok; underflow sets on rd_en & empty.
  - Both remain set until clr_err.
  - If clr_err and a new error occur in the same cycle, the flag stays set (set wins).
- Ordering: strict FIFO; no word lost or duplicated across pointer wrap.

Test Plan (FIFO_WIDTH=8, FIFO_DEPTH=6, AF_LEVEL=4, AE_LEVEL=1, FWFT=0 unless noted):
1. Reset, then write 0x11..0x16 on 6 consecutive cycles:
   - count steps 1..6; almost_empty drops after count=2; almost_full rises at count=4.
   - full=1 after the 6th write.
   - 7th write of 0x77 → rejected, overflow=1, count stays 6.
2. From full, rd_en and wr_en (0x88) in the same cycle:
   - data_out=0x11 next cycle, count stays 6, full stays 1, overflow unchanged.
   - Drain all words → 0x12..0x16, then 0x88 in order.
3. Wrap check: 20 interleaved single writes/reads of incrementing data (pointers wrap past index 5 three times):
   - every read returns the matching write value.
   - count never exceeds 1.
4. Empty FIFO, rd_en with wr_en=0x5A:
   - underflow=1, count=1, data_out unchanged.
   - Pulse clr_err → underflow=0 next cycle.
   - clr_err coincident with another empty read → underflow stays 1.
5. FWFT=1: write 0xA5 into empty FIFO:
   - next cycle empty=0 and data_out=0xA5 with no rd_en.
   - rd_en one cycle → empty=1, count=0.
6. Mid-stream reset: 3 words stored, assert rstN=0 between edges:
   - outputs immediately return to reset values.
   - After release, first write 0x3C reads back as 0x3C (no stale data).
